// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with break detection.
// Bytes equal to KEY are delivered bit-inverted when KEY_INV_EN is set.
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          KEY_INV_EN   = 1'b1,
    parameter logic [PAYLOAD_BITS-1:0] KEY = 8'hAB
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB + 1);
    localparam int unsigned BW   = $clog2(PAYLOAD_BITS + 1);
    localparam int unsigned SW   = $clog2(STOP_BITS + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CYC_HALF  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RECV,
        STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                    rxd_meta;
    logic                    rxd_sync;
    logic [CW-1:0]           cyc_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [SW-1:0]           stop_cnt;
    logic [PAYLOAD_BITS-1:0] shift;
    logic                    stop_ok;

    logic                    tick;
    logic                    half_tick;
    logic                    done;
    logic                    stop_good;
    logic                    is_zero;
    logic                    valid_nxt;
    logic                    break_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;

    assign tick      = (cyc_cnt == CYC_LAST);
    assign half_tick = (cyc_cnt == CYC_HALF);

    // Two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a disabled receiver always falls back to IDLE
    always_comb begin
        state_nxt = state;
        if (!uart_rx_en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rxd_sync) state_nxt = START;
                end
                START: begin
                    if (rxd_sync) state_nxt = IDLE;
                    else if (half_tick) state_nxt = RECV;
                end
                RECV: begin
                    if (tick && bit_cnt == BIT_LAST) state_nxt = STOP;
                end
                STOP: begin
                    if (tick && stop_cnt == STOP_LAST) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit timing, payload shifter and stop-bit accumulation
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            shift    <= '0;
            stop_ok  <= 1'b1;
        end else begin
            if (state != state_nxt || state == IDLE || tick) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (state != RECV) begin
                bit_cnt <= '0;
            end else if (tick) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= {rxd_sync, shift[PAYLOAD_BITS-1:1]};
            end
            if (state != STOP) begin
                stop_cnt <= '0;
                stop_ok  <= 1'b1;
            end else if (tick) begin
                stop_cnt <= stop_cnt + 1'b1;
                stop_ok  <= stop_ok & rxd_sync;
            end
        end
    end

    // Frame outcome: good byte, break, or silently dropped framing error
    always_comb begin
        done      = (state == STOP) && uart_rx_en && tick
                    && (stop_cnt == STOP_LAST);
        stop_good = stop_ok & rxd_sync;
        is_zero   = (shift == '0);
        valid_nxt = done && (stop_good || is_zero);
        break_nxt = done && !stop_good && is_zero;
        data_nxt  = '0;
        if (stop_good) begin
            if (KEY_INV_EN && shift == KEY) data_nxt = ~shift;
            else data_nxt = shift;
        end
    end

    // Output registers; data only moves on a strobe
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            uart_rx_valid <= valid_nxt;
            uart_rx_break <= break_nxt;
            if (valid_nxt) uart_rx_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Two instances differ only in KEY_INV_EN.
module tb_uart_rx;

    localparam time BIT = 320ns;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       en;
    logic       v_inv, b_inv, v_raw, b_raw;
    logic [7:0] d_inv, d_raw;

    int checks = 0;
    int errors = 0;

    logic [8:0] q_inv[$];
    logic [8:0] q_raw[$];

    always #10ns clk = ~clk;

    uart_rx #(
        .BIT_RATE(3_125_000), .CLK_HZ(50_000_000),
        .PAYLOAD_BITS(8), .STOP_BITS(1),
        .KEY_INV_EN(1'b1), .KEY(8'hAB)
    ) u_inv (
        .clk(clk), .resetn(rst), .uart_rxd(rxd), .uart_rx_en(en),
        .uart_rx_break(b_inv), .uart_rx_valid(v_inv),
        .uart_rx_data(d_inv)
    );

    uart_rx #(
        .BIT_RATE(3_125_000), .CLK_HZ(50_000_000),
        .PAYLOAD_BITS(8), .STOP_BITS(1),
        .KEY_INV_EN(1'b0), .KEY(8'hAB)
    ) u_raw (
        .clk(clk), .resetn(rst), .uart_rxd(rxd), .uart_rx_en(en),
        .uart_rx_break(b_raw), .uart_rx_valid(v_raw),
        .uart_rx_data(d_raw)
    );

    // Monitor for the inverting instance
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && v_inv) begin
            checks++;
            if (q_inv.size() == 0) begin
                errors++;
                $display("FAIL inv_unexpected got brk=%0b data=%02h required no strobe",
                         b_inv, d_inv);
            end else begin
                e = q_inv.pop_front();
                if ({b_inv, d_inv} !== e) begin
                    errors++;
                    $display("FAIL inv_frame got brk=%0b data=%02h required brk=%0b data=%02h",
                             b_inv, d_inv, e[8], e[7:0]);
                end
            end
        end
        if (!rst && b_inv && !v_inv) begin
            errors++;
            $display("FAIL inv_break_alone got brk=1 valid=0 required brk=0");
        end
    end

    // Monitor for the non-inverting instance
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && v_raw) begin
            checks++;
            if (q_raw.size() == 0) begin
                errors++;
                $display("FAIL raw_unexpected got brk=%0b data=%02h required no strobe",
                         b_raw, d_raw);
            end else begin
                e = q_raw.pop_front();
                if ({b_raw, d_raw} !== e) begin
                    errors++;
                    $display("FAIL raw_frame got brk=%0b data=%02h required brk=%0b data=%02h",
                             b_raw, d_raw, e[8], e[7:0]);
                end
            end
        end
        if (!rst && b_raw && !v_raw) begin
            errors++;
            $display("FAIL raw_break_alone got brk=1 valid=0 required brk=0");
        end
    end

    task automatic check(input string name, input logic [8:0] got,
                         input logic [8:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %03h required %03h", name, got, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            q_inv.push_back({1'b0, (b == 8'hAB) ? ~b : b});
            q_raw.push_back({1'b0, b});
        end else if (b == 8'h00) begin
            q_inv.push_back(9'h100);
            q_raw.push_back(9'h100);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input int gap);
        expect_frame(b, stop);
        rxd = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT);
        end
        rxd = stop;
        #(BIT);
        rxd = 1'b1;
        repeat (gap) #(BIT);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1;
        rxd = 1'b1;
        en  = 1'b1;
        #20ns;
        check("rst_valid_inv", {8'h00, v_inv}, 9'h000);
        check("rst_break_inv", {8'h00, b_inv}, 9'h000);
        check("rst_data_inv",  {1'b0, d_inv},  9'h000);
        check("rst_valid_raw", {8'h00, v_raw}, 9'h000);
        check("rst_break_raw", {8'h00, b_raw}, 9'h000);
        check("rst_data_raw",  {1'b0, d_raw},  9'h000);
        #20ns;
        rst = 1'b0;
        #1000ns;

        send(8'hAA, 1'b1, 1);
        send(8'hAB, 1'b1, 1);

        // Line held low ten bit times: break
        expect_frame(8'h00, 1'b0);
        rxd = 1'b0;
        #(10 * BIT);
        rxd = 1'b1;
        #(2 * BIT);

        // Nonzero payload with bad stop bit: dropped
        send(8'h12, 1'b0, 2);
        send(8'h00, 1'b1, 1);
        send(8'hFF, 1'b1, 1);

        // Back-to-back frames with no idle gap
        send(8'h01, 1'b1, 0);
        send(8'h80, 1'b1, 1);
        send(8'h54, 1'b1, 1);

        // Receiver disabled part way through 8'h55
        pat = 8'h55;
        rxd = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = pat[i];
            if (i == 2) en = 1'b0;
            #(BIT);
        end
        rxd = 1'b1;
        #(2 * BIT);
        en = 1'b1;
        #(BIT);
        send(8'h3C, 1'b1, 1);
        check("hold_after_3c_inv", {1'b0, d_inv}, 9'h03C);

        // Reset in the middle of a frame
        rxd = 1'b0;
        #(BIT);
        for (int i = 0; i < 3; i++) begin
            rxd = pat[i];
            #(BIT);
        end
        rst = 1'b1;
        rxd = 1'b1;
        #40ns;
        rst = 1'b0;
        #(2 * BIT);
        check("rst_mid_data_inv", {1'b0, d_inv}, 9'h000);
        check("rst_mid_data_raw", {1'b0, d_raw}, 9'h000);
        send(8'h0F, 1'b1, 1);

        // Short low glitch, well under half a bit
        rxd = 1'b0;
        #100ns;
        rxd = 1'b1;
        #(4 * BIT);

        check("pending_inv", 9'(q_inv.size()), 9'h000);
        check("pending_raw", 9'(q_raw.size()), 9'h000);
        check("final_data_inv", {1'b0, d_inv}, 9'h00F);
        check("final_data_raw", {1'b0, d_raw}, 9'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
